// File: rtl/mul_div_unit_if.sv
// Start/Busy/Done request bundle between the EX stage and the iterative
// RV32M multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            Flush;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output Start, Funct3, SrcA, SrcB, Flush,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Funct3, SrcA, SrcB, Flush,
    output Busy, Done, Result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with sign fixup on the way to DONE.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, nextState;
  logic [2:0]        f3;
  logic [XLEN-1:0]   opReg;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;
  logic              negRes, negRem;
  logic [XLEN-1:0]   resultReg;

  logic              signedA, signedB, sA, sB;
  logic [XLEN-1:0]   magA, magB;
  logic              divZero, divOvf, fastPath, accept;
  logic [XLEN-1:0]   fastResult;
  logic [XLEN:0]     mulSum, divShift, divTrial;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient, remainder, finalResult;

  assign bus.Busy   = (state == MUL) || (state == DIV);
  assign bus.Done   = (state == DONE);
  assign bus.Result = resultReg;

  // Operand signedness and the two division corner cases resolved at issue
  always_comb begin
    signedA = 1'b0;
    signedB = 1'b0;
    case (bus.Funct3)
      3'b001, 3'b100, 3'b110: begin
        signedA = 1'b1;
        signedB = 1'b1;
      end
      3'b010:  signedA = 1'b1;
      default: ;
    endcase
  end

  assign sA       = signedA & bus.SrcA[XLEN-1];
  assign sB       = signedB & bus.SrcB[XLEN-1];
  assign magA     = sA ? -bus.SrcA : bus.SrcA;
  assign magB     = sB ? -bus.SrcB : bus.SrcB;
  assign accept   = bus.Start && !bus.Flush;
  assign divZero  = bus.Funct3[2] && (bus.SrcB == '0);
  assign divOvf   = bus.Funct3[2] && !bus.Funct3[0] &&
                    (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == '1);
  assign fastPath = divZero || divOvf;

  // Funct3[1] separates REM from DIV in both corner cases
  always_comb begin
    if (divZero)
      fastResult = bus.Funct3[1] ? bus.SrcA : '1;
    else
      fastResult = bus.Funct3[1] ? '0 : bus.SrcA;
  end

  // acc holds {hi, multiplier} for MUL and {remainder, quotient} for DIV
  assign mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opReg} : '0);
  assign divShift = acc[2*XLEN-1:XLEN-1];
  assign divTrial = divShift - {1'b0, opReg};

  assign product   = negRes ? -acc : acc;
  assign quotient  = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign remainder = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    case (f3)
      3'b000:                 finalResult = product[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finalResult = product[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finalResult = quotient;
      default:                finalResult = remainder;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fastPath)
            nextState = DONE;
          else
            nextState = bus.Funct3[2] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        if (bus.Flush)
          nextState = IDLE;
        else if (count == '0)
          nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: operands latched at issue, one iteration per cycle after that
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f3        <= '0;
      opReg     <= '0;
      acc       <= '0;
      count     <= '0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      resultReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3     <= bus.Funct3;
            count  <= CW'(XLEN);
            negRes <= sA ^ sB;
            negRem <= sA;
            acc    <= {{XLEN{1'b0}}, (bus.Funct3[2] ? magA : magB)};
            opReg  <= bus.Funct3[2] ? magB : magA;
            if (fastPath)
              resultReg <= fastResult;
          end
        end
        MUL: begin
          if (!bus.Flush) begin
            if (count != '0) begin
              acc   <= {mulSum, acc[XLEN-1:1]};
              count <= count - 1'b1;
            end else begin
              resultReg <= finalResult;
            end
          end
        end
        DIV: begin
          if (!bus.Flush) begin
            if (count != '0) begin
              if (!divTrial[XLEN])
                acc <= {divTrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
              else
                acc <= {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
              count <= count - 1'b1;
            end else begin
              resultReg <= finalResult;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every Done.
module tb_mul_div_unit;

  localparam int XLEN = 32;

  typedef struct {
    string           name;
    logic [XLEN-1:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mul_div_unit_if #(.XLEN(XLEN)) bus ();

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t expQ[$];
  logic [XLEN-1:0] lastResult = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  // Scoreboard monitor: every Done must match the oldest outstanding expectation
  exp_t popped;
  always @(negedge clk) begin
    if (reset_n && bus.Done === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: actual=Done with Result=0x%08h required=no Done", bus.Result);
      end else begin
        popped = expQ.pop_front();
        checkOutput(popped.name, bus.Result, popped.value);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [2:0] f3,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] expected, input bit fast);
    int n = 0;
    int busyCycles = 0;
    bit seen = 0;
    bus.Start  = 1'b1;
    bus.Funct3 = f3;
    bus.SrcA   = a;
    bus.SrcB   = b;
    expQ.push_back('{name, expected});
    @(negedge clk);
    n = 1;
    bus.Start = 1'b0;
    bus.SrcA  = ~a;
    bus.SrcB  = ~b;
    while (!seen && n < 100) begin
      if (bus.Busy === 1'b1) busyCycles++;
      if (bus.Done === 1'b1) begin
        seen = 1;
      end else begin
        @(negedge clk);
        n++;
        // A Start while busy must be ignored
        if (n == 3) begin
          bus.Start  = 1'b1;
          bus.Funct3 = ~f3;
        end else if (n == 4) begin
          bus.Start = 1'b0;
        end
      end
    end
    bus.Start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: actual=no Done after %0d cycles required=Done", name, n);
    end else begin
      checkOutput({name, "_latency"}, 32'(n), fast ? 32'd1 : 32'd34);
      checkOutput({name, "_busy_cycles"}, 32'(busyCycles), fast ? 32'd0 : 32'd33);
      checkOutput({name, "_busy_in_done"}, {31'd0, bus.Busy}, 32'd0);
    end
    @(negedge clk);
    checkOutput({name, "_done_pulse"}, {31'd0, bus.Done}, 32'd0);
    lastResult = expected;
  endtask

  initial begin
    bus.Start  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    bus.Flush  = 1'b0;

    #1;
    checkOutput("reset_busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.Done}, 32'd0);
    checkOutput("reset_result", bus.Result, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus("mul_7xm3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    applyStimulus("mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    applyStimulus("mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    applyStimulus("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
    applyStimulus("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
    applyStimulus("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0);
    applyStimulus("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        0);
    applyStimulus("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       0);
    applyStimulus("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        0);
    applyStimulus("divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    applyStimulus("rem_5_0",      3'b110, 32'd5,        32'd0,        32'd5,        1);
    applyStimulus("div_m7_0",     3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
    applyStimulus("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    applyStimulus("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Flush mid-divide: no Done, Result keeps the previous value
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b100;
    bus.SrcA   = 32'd1000;
    bus.SrcB   = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      if (c == 5) begin
        bus.SrcA  = 32'd77;
        bus.SrcB  = 32'd5;
        bus.Start = 1'b1;
      end
      if (c == 10) bus.Flush = 1'b1;
    end
    @(negedge clk);
    bus.Flush = 1'b0;
    checkOutput("flush_busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("flush_done", {31'd0, bus.Done}, 32'd0);
    checkOutput("flush_result", bus.Result, lastResult);
    repeat (40) @(negedge clk);
    applyStimulus("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 0);

    // Asynchronous reset in the middle of a multiply
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd5;
    bus.SrcB   = 32'd6;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      bus.Start = 1'b0;
    end
    @(negedge clk);
    checkOutput("pre_reset_busy", {31'd0, bus.Busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("async_reset_done", {31'd0, bus.Done}, 32'd0);
    checkOutput("async_reset_result", bus.Result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    lastResult = '0;
    repeat (40) @(negedge clk);

    // Flush wins over Start in IDLE
    bus.Start  = 1'b1;
    bus.Flush  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd2;
    bus.SrcB   = 32'd2;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    checkOutput("flush_start_busy", {31'd0, bus.Busy}, 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("flush_start_result", bus.Result, 32'd0);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
